// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared types and constants for the DDS generation controller
package dds_ctrl_pkg;
    localparam int NUM_ACC = 3;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, RUN, GAP, RECOVER} state_t;
    localparam logic [1:0] TYPE_TONE = 2'd0;
    localparam logic [1:0] TYPE_LFM  = 2'd1;
    localparam logic [1:0] TYPE_PSK  = 2'd2;
    localparam logic [1:0] TYPE_RSVD = 2'd3;
    localparam logic [1:0] ERR_START_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RSVD_TYPE     = 2'd2;
    localparam logic [1:0] ERR_ABORT         = 2'd3;
    // The reserved type selects no accumulator.
    function automatic logic [NUM_ACC-1:0] acc_sel(input logic [1:0] t);
        return {t == TYPE_PSK, t == TYPE_LFM, t == TYPE_TONE};
    endfunction
endpackage

// File: rtl/dds_gen_controller_if.sv
// dds_gen_controller_if: host command handshake and status bundle
// master = host/config register file, slave = dds_gen_controller
interface dds_gen_controller_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_SIGNAL_TYPE;
    logic [7:0] CMD_REPEAT;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [1:0] ERR_CODE;
    logic [7:0] PKT_CNT;
    modport master (
        output CMD_VALID, CMD_SIGNAL_TYPE, CMD_REPEAT,
        input  CMD_READY, BUSY, DONE, ERR, ERR_CODE, PKT_CNT
    );
    modport slave (
        input  CMD_VALID, CMD_SIGNAL_TYPE, CMD_REPEAT,
        output CMD_READY, BUSY, DONE, ERR, ERR_CODE, PKT_CNT
    );
endinterface

// File: rtl/dds_watchdog_cnt.sv
// dds_watchdog_cnt: 32-bit saturating watchdog counter
// CLK/RESET; clr zeroes, en counts up to limit; hit is high on the cycle the limit is reached
module dds_watchdog_cnt (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic        hit
);
    logic [31:0] cnt;
    always_ff @(posedge CLK) begin
        if (RESET || clr) cnt <= '0;
        else if (en && cnt < limit) cnt <= cnt + 32'd1;
    end
    // cnt holds cycles already elapsed, so the current cycle is cnt+1
    assign hit = {1'b0, cnt} + 33'd1 >= {1'b0, limit};
endmodule

// File: rtl/dds_gen_controller.sv
// dds_gen_controller: launches, repeats and supervises DDS accumulator packets
// host: command handshake + BUSY/DONE/ERR/ERR_CODE/PKT_CNT; ABORT, OUT_REG_READY in;
// SIGNAL_TYPE, ACC_START, ACC_RESET out; ACC_START_CALC/ACC_STOP_CALC flags in
module dds_gen_controller
    import dds_ctrl_pkg::*;
#(
    parameter int          START_TIMEOUT = 64,
    parameter logic [31:0] RUN_TIMEOUT   = 32'hFFFF_FFFF,
    parameter int          GAP_CYCLES    = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    dds_gen_controller_if.slave  host,
    input  logic                 ABORT,
    input  logic                 OUT_REG_READY,
    output logic [1:0]           SIGNAL_TYPE,
    output logic [NUM_ACC-1:0]   ACC_START,
    output logic [NUM_ACC-1:0]   ACC_RESET,
    input  logic [NUM_ACC-1:0]   ACC_START_CALC,
    input  logic [NUM_ACC-1:0]   ACC_STOP_CALC
);
    state_t             st;
    logic [7:0]         rep;
    logic [8:0]         pkt;
    logic [7:0]         gap;
    logic [NUM_ACC-1:0] sel;
    logic               started;
    logic               stopped;
    logic               wd_hit;
    assign sel     = acc_sel(SIGNAL_TYPE);
    assign started = |(ACC_START_CALC & sel);
    assign stopped = |(ACC_STOP_CALC & sel);
    // 9-bit count so a 256-packet command still terminates while PKT_CNT wraps
    assign host.PKT_CNT = pkt[7:0];
    dds_watchdog_cnt u_wd (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (st == LAUNCH || (st == WAIT_START && started)),
        .en    (st == WAIT_START || st == RUN),
        .limit (st == RUN ? RUN_TIMEOUT : 32'(START_TIMEOUT)),
        .hit   (wd_hit)
    );
    always_ff @(posedge CLK) begin
        if (RESET) begin
            st             <= IDLE;
            SIGNAL_TYPE    <= TYPE_TONE;
            rep            <= '0;
            pkt            <= '0;
            gap            <= '0;
            ACC_START      <= '0;
            ACC_RESET      <= '0;
            host.CMD_READY <= 1'b1;
            host.BUSY      <= 1'b0;
            host.DONE      <= 1'b0;
            host.ERR       <= 1'b0;
            host.ERR_CODE  <= '0;
        end else begin
            ACC_START <= '0;
            ACC_RESET <= '0;
            host.DONE <= 1'b0;
            host.ERR  <= 1'b0;
            // RECOVER already resets the accumulator, so a held ABORT is not re-taken there
            if (ABORT && st != IDLE && st != RECOVER) begin
                st            <= RECOVER;
                ACC_RESET     <= sel;
                host.ERR      <= 1'b1;
                host.ERR_CODE <= ERR_ABORT;
            end else begin
                case (st)
                    IDLE: if (host.CMD_VALID) begin
                        SIGNAL_TYPE <= host.CMD_SIGNAL_TYPE;
                        rep         <= host.CMD_REPEAT;
                        pkt         <= '0;
                        if (host.CMD_SIGNAL_TYPE == TYPE_RSVD) begin
                            host.ERR      <= 1'b1;
                            host.ERR_CODE <= ERR_RSVD_TYPE;
                        end else begin
                            st             <= LAUNCH;
                            host.CMD_READY <= 1'b0;
                            host.BUSY      <= 1'b1;
                        end
                    end
                    LAUNCH: if (OUT_REG_READY) begin
                        ACC_START <= sel;
                        st        <= WAIT_START;
                    end
                    WAIT_START: if (started) begin
                        st <= RUN;
                    end else if (wd_hit) begin
                        st            <= RECOVER;
                        ACC_RESET     <= sel;
                        host.ERR      <= 1'b1;
                        host.ERR_CODE <= ERR_START_TIMEOUT;
                    end
                    RUN: if (stopped) begin
                        pkt <= pkt + 9'd1;
                        gap <= '0;
                        st  <= GAP;
                    end else if (wd_hit) begin
                        st            <= RECOVER;
                        ACC_RESET     <= sel;
                        host.ERR      <= 1'b1;
                        host.ERR_CODE <= ERR_START_TIMEOUT;
                    end
                    GAP: if (gap == 8'(GAP_CYCLES)) begin
                        if (pkt == {1'b0, rep} + 9'd1) begin
                            host.DONE      <= 1'b1;
                            host.CMD_READY <= 1'b1;
                            host.BUSY      <= 1'b0;
                            st             <= IDLE;
                        end else begin
                            st <= LAUNCH;
                        end
                    end else begin
                        gap <= gap + 8'd1;
                    end
                    RECOVER: begin
                        st             <= IDLE;
                        host.CMD_READY <= 1'b1;
                        host.BUSY      <= 1'b0;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dds_gen_controller.sv
// tb_dds_gen_controller: randomized self-checking bench with a timeline model of the controller
module tb_dds_gen_controller;
    import dds_ctrl_pkg::*;
    localparam int ST_TO  = 64;
    localparam int RUN_TO = 300;
    localparam int GAPC   = 2;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ABORT = 1'b0;
    logic       OUT_REG_READY = 1'b0;
    logic [1:0] SIGNAL_TYPE;
    logic [2:0] ACC_START;
    logic [2:0] ACC_RESET;
    logic [2:0] ACC_START_CALC = 3'b000;
    logic [2:0] ACC_STOP_CALC = 3'b000;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int viol = 0;
    int orr_from = 0;
    int abort_at = -1;
    int acc_ds = 1;
    int acc_dr = 1;
    logic [1:0] last_code = 2'd0;
    int         s_cyc[$];
    logic [2:0] s_vec[$];
    int         r_cyc[$];
    logic [2:0] r_vec[$];
    int         d_cyc[$];
    int         e_cyc[$];
    logic [1:0] e_code[$];
    dds_gen_controller_if h();
    dds_gen_controller #(
        .START_TIMEOUT (ST_TO),
        .RUN_TIMEOUT   (32'(RUN_TO)),
        .GAP_CYCLES    (GAPC)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .host           (h),
        .ABORT          (ABORT),
        .OUT_REG_READY  (OUT_REG_READY),
        .SIGNAL_TYPE    (SIGNAL_TYPE),
        .ACC_START      (ACC_START),
        .ACC_RESET      (ACC_RESET),
        .ACC_START_CALC (ACC_START_CALC),
        .ACC_STOP_CALC  (ACC_STOP_CALC)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // Event log of DUT outputs, stamped with the edge number that produced them.
    initial forever begin
        @(negedge CLK);
        if (!RESET) begin
            if (ACC_START != 3'b000) begin s_cyc.push_back(cyc); s_vec.push_back(ACC_START); end
            if (ACC_RESET != 3'b000) begin r_cyc.push_back(cyc); r_vec.push_back(ACC_RESET); end
            if (h.DONE) d_cyc.push_back(cyc);
            if (h.ERR) begin e_cyc.push_back(cyc); e_code.push_back(h.ERR_CODE); end
            if (!$onehot0(ACC_START) || !$onehot0(ACC_RESET) || (ACC_START != 3'b000 && ACC_RESET != 3'b000)) viol++;
        end
    end
    // Accumulator model: START_CALC acc_ds edges after the start, STOP_CALC acc_dr later; noise on other accumulators.
    initial begin
        int st_at;
        int sp_at;
        logic [2:0] vec;
        st_at = -1;
        sp_at = -1;
        vec = 3'b000;
        forever begin
            @(negedge CLK);
            if (RESET || ACC_RESET != 3'b000) begin st_at = -1; sp_at = -1; end
            if (ACC_START != 3'b000) begin
                vec = ACC_START;
                st_at = cyc + acc_ds;
                sp_at = cyc + acc_ds + acc_dr;
            end
            ACC_START_CALC = (cyc + 1 == st_at ? vec : 3'b000) | (3'($urandom) & ~vec);
            ACC_STOP_CALC  = (cyc + 1 == sp_at ? vec : 3'b000) | (3'($urandom) & ~vec);
            ABORT = (cyc + 1 == abort_at);
            OUT_REG_READY = (cyc + 1 >= orr_from);
        end
    end
    // abk >= 0 raises ABORT on the edge that samples STOP_CALC of packet abk.
    task automatic run_cmd(input string nm, input logic [1:0] t, input int r, input int ds, input int dr, input int rlo, input int abk);
        int a, s, n, w, stride, ecyc, dcyc, pk;
        logic [1:0] ecode;
        logic [2:0] oh;
        logic rsvd, sto, rto;
        s_cyc.delete(); s_vec.delete(); r_cyc.delete(); r_vec.delete();
        d_cyc.delete(); e_cyc.delete(); e_code.delete();
        @(negedge CLK);
        a = cyc + 1;
        oh = 3'b001 << t;
        rsvd = (t == TYPE_RSVD);
        sto = !rsvd && ds > ST_TO;
        rto = !rsvd && !sto && dr > RUN_TO;
        s = a + 1 + rlo;
        stride = ds + dr + GAPC + 2;
        n = rsvd ? 0 : (sto || rto) ? 1 : (abk >= 0) ? abk + 1 : r + 1;
        orr_from = s;
        acc_ds = ds;
        acc_dr = dr;
        abort_at = (abk >= 0) ? s + abk * stride + ds + dr : -1;
        ecode = rsvd ? 2'd2 : (sto || rto) ? 2'd1 : (abk >= 0) ? 2'd3 : 2'd0;
        ecyc = rsvd ? a : sto ? s + ST_TO : rto ? s + ds + RUN_TO : (abk >= 0) ? abort_at : -1;
        dcyc = (ecode == 2'd0) ? s + r * stride + ds + dr + GAPC + 1 : -1;
        pk = (rsvd || sto || rto) ? 0 : (abk >= 0) ? abk : (r + 1) % 256;
        h.CMD_VALID = 1'b1;
        h.CMD_SIGNAL_TYPE = t;
        h.CMD_REPEAT = 8'(r);
        @(negedge CLK);
        h.CMD_VALID = 1'b0;
        check({nm, " ready_after_accept"}, h.CMD_READY, rsvd);
        w = 0;
        while (!h.CMD_READY && w < 20000) begin @(negedge CLK); w++; end
        check({nm, " idle_within_budget"}, w < 20000, 1);
        repeat (2) @(negedge CLK);
        check({nm, " start_count"}, s_cyc.size(), n);
        for (int i = 0; i < n && i < s_cyc.size(); i++) begin
            check({nm, " start_cycle"}, s_cyc[i], s + i * stride);
            check({nm, " start_vec"}, s_vec[i], oh);
        end
        check({nm, " err_count"}, e_cyc.size(), ecyc >= 0);
        if (ecyc >= 0 && e_cyc.size() > 0) begin
            check({nm, " err_cycle"}, e_cyc[0], ecyc);
            check({nm, " err_code"}, e_code[0], ecode);
        end
        check({nm, " reset_count"}, r_cyc.size(), ecyc >= 0 && !rsvd);
        if (ecyc >= 0 && !rsvd && r_cyc.size() > 0) begin
            check({nm, " reset_cycle"}, r_cyc[0], ecyc);
            check({nm, " reset_vec"}, r_vec[0], oh);
        end
        check({nm, " done_count"}, d_cyc.size(), dcyc >= 0);
        if (dcyc >= 0 && d_cyc.size() > 0) check({nm, " done_cycle"}, d_cyc[0], dcyc);
        check({nm, " pkt_cnt"}, h.PKT_CNT, pk);
        check({nm, " signal_type"}, SIGNAL_TYPE, t);
        check({nm, " busy_idle"}, h.BUSY, 0);
        if (ecode != 2'd0) last_code = ecode;
        check({nm, " err_code_hold"}, h.ERR_CODE, last_code);
        check({nm, " onehot_violations"}, viol, 0);
        abort_at = -1;
    endtask
    initial begin
        int r;
        h.CMD_VALID = 1'b0;
        h.CMD_SIGNAL_TYPE = 2'd0;
        h.CMD_REPEAT = 8'd0;
        repeat (3) @(negedge CLK);
        check("reset_state", {h.CMD_READY, SIGNAL_TYPE, ACC_START, ACC_RESET, h.BUSY, h.DONE, h.ERR, h.ERR_CODE, h.PKT_CNT}, {1'b1, 21'd0});
        RESET = 1'b0;
        run_cmd("lfm_single", TYPE_LFM, 0, 24, 100, 0, -1);
        run_cmd("tone_rep2", TYPE_TONE, 2, 10, 30, 0, -1);
        run_cmd("rsvd_type", TYPE_RSVD, 5, 1, 1, 0, -1);
        run_cmd("psk_start_to", TYPE_PSK, 0, 1000, 1, 0, -1);
        run_cmd("start_at_limit", TYPE_LFM, 1, ST_TO, 5, 0, -1);
        run_cmd("start_late", TYPE_TONE, 0, ST_TO + 1, 5, 0, -1);
        run_cmd("out_reg_low50", TYPE_PSK, 0, 8, 8, 50, -1);
        run_cmd("abort_on_stop", TYPE_LFM, 2, 6, 12, 0, 1);
        run_cmd("run_timeout", TYPE_TONE, 0, 3, RUN_TO + 1, 0, -1);
        run_cmd("stop_at_limit", TYPE_PSK, 0, 3, RUN_TO, 0, -1);
        run_cmd("rep255_wrap", TYPE_PSK, 255, 1, 1, 0, -1);
        @(negedge CLK);
        acc_ds = 5;
        acc_dr = 20;
        h.CMD_VALID = 1'b1;
        h.CMD_SIGNAL_TYPE = TYPE_PSK;
        h.CMD_REPEAT = 8'd3;
        @(negedge CLK);
        h.CMD_VALID = 1'b0;
        repeat (45) @(negedge CLK);
        check("mid_run_busy", h.BUSY, 1);
        check("mid_run_pkt", h.PKT_CNT, 1);
        RESET = 1'b1;
        @(negedge CLK);
        check("mid_run_reset_state", {h.CMD_READY, SIGNAL_TYPE, ACC_START, ACC_RESET, h.BUSY, h.DONE, h.ERR, h.ERR_CODE, h.PKT_CNT}, {1'b1, 21'd0});
        RESET = 1'b0;
        last_code = 2'd0;
        @(negedge CLK);
        check("mid_run_no_acc_reset", ACC_RESET, 0);
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 3);
            run_cmd("random", 2'($urandom_range(0, 2)), r, $urandom_range(1, 40), $urandom_range(1, 60),
                    $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? $urandom_range(0, r) : -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
